// File: rtl/toaster_top.sv
// Toaster sequencing controller: a debounced start/abort press walks
// IDLE -> WARMUP -> TOAST -> COOL_DOWN -> IDLE with a per-state dwell time.
module toaster_top #(
   parameter int WARMUP_CYCLES = 8,
   parameter int TOAST_CYCLES  = 16,
   parameter int COOL_CYCLES   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iiA,
   output logic [1:0] state_int
);

   localparam int MAX_A  = (WARMUP_CYCLES > TOAST_CYCLES) ? WARMUP_CYCLES : TOAST_CYCLES;
   localparam int MAX_C  = (MAX_A > COOL_CYCLES) ? MAX_A : COOL_CYCLES;
   localparam int CW     = $clog2(MAX_C) + 1;

   localparam logic [CW-1:0] WARM_LAST  = CW'(WARMUP_CYCLES - 1);
   localparam logic [CW-1:0] TOAST_LAST = CW'(TOAST_CYCLES - 1);
   localparam logic [CW-1:0] COOL_LAST  = CW'(COOL_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      WARMUP    = 2'b01,
      TOAST     = 2'b10,
      COOL_DOWN = 2'b11
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          s1_q, s1_d;
   logic          s2_q, s2_d;
   logic          s3_q, s3_d;
   logic          press;

   // s1/s2 resynchronise the button; s3 gives the previous value for edge detect.
   assign press = s2_q & ~s3_q;

   always_comb begin
      s1_d = iiA;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (press) state_d = WARMUP;
         end
         WARMUP: begin
            if (press)                   state_d = COOL_DOWN;
            else if (cnt_q == WARM_LAST) state_d = TOAST;
         end
         TOAST: begin
            if (press)                    state_d = COOL_DOWN;
            else if (cnt_q == TOAST_LAST) state_d = COOL_DOWN;
         end
         COOL_DOWN: begin
            if (cnt_q == COOL_LAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Dwell count restarts on every state change; held at zero while idle.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if ((state_d != state_q) || (state_q == IDLE)) cnt_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         s3_q    <= s3_d;
      end
   end

   assign state_int = state_q;

endmodule

// File: tb/tb_toaster_top.sv
// Bench for toaster_top: deadline-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized button activity.
module tb_toaster_top;

   localparam int W_CYC = 8;
   localparam int T_CYC = 16;
   localparam int C_CYC = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       iiA = 1'b0;
   logic [1:0] state_int;

   int n_cmp = 0;
   int n_bad = 0;
   int ec    = 0;

   toaster_top #(
      .WARMUP_CYCLES(W_CYC),
      .TOAST_CYCLES (T_CYC),
      .COOL_CYCLES  (C_CYC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .iiA      (iiA),
      .state_int(state_int)
   );

   // ---------------- clock / edge counter ----------------
   initial forever #5 clk = ~clk;

   always @(posedge clk) ec <= ec + 1;

   // ---------------- reference model ----------------
   // samp[0..2] hold the button as seen at the previous three edges.
   // The model tracks the mode and the absolute edge at which it times out.
   int mode     = 0;
   int deadline = 0;
   int cyc      = 0;
   bit samp[$]  = '{1'b0, 1'b0, 1'b0};

   always @(posedge clk or posedge rst) begin
      bit pr;
      if (rst) begin
         samp = '{1'b0, 1'b0, 1'b0};
         mode = 0;
      end else begin
         cyc = cyc + 1;
         pr  = samp[1] && !samp[2];
         case (mode)
            0: if (pr) begin mode = 1; deadline = cyc + W_CYC; end
            1: if (pr) begin mode = 3; deadline = cyc + C_CYC; end
               else if (cyc == deadline) begin mode = 2; deadline = cyc + T_CYC; end
            2: if (pr || cyc == deadline) begin mode = 3; deadline = cyc + C_CYC; end
            default: if (cyc == deadline) mode = 0;
         endcase
         samp.push_front(iiA);
         void'(samp.pop_back());
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic [1:0] exp_s;
      exp_s = rst ? 2'b00 : 2'(mode);
      n_cmp = n_cmp + 1;
      if (state_int !== exp_s) begin
         n_bad = n_bad + 1;
         $display("FAIL model_cmp t=%0t: state_int=%b expected=%b", $time, state_int, exp_s);
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [1:0] exp_s);
      n_cmp = n_cmp + 1;
      if (state_int !== exp_s) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: state_int=%b expected=%b", name, state_int, exp_s);
      end
   endtask

   // Returns 1 time unit after edge number n (n must not be in the past).
   task automatic at_edge(input int n);
      while (ec < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int k;

      // 1: reset with button toggling, then idle
      repeat (6) begin
         @(negedge clk);
         iiA = ~iiA;
         #1 chk("reset_hold", 2'b00);
      end
      @(negedge clk);
      iiA = 1'b0;
      rst = 1'b0;
      repeat (50) @(posedge clk);
      #1 chk("idle_50", 2'b00);

      // 2 + 4: full run with button held for 100 cycles
      k = ec + 2;
      at_edge(k - 1); iiA = 1'b1;
      at_edge(k + 1);  chk("run_k1", 2'b00);
      at_edge(k + 2);  chk("run_k2", 2'b01);
      at_edge(k + 9);  chk("run_k9", 2'b01);
      at_edge(k + 10); chk("run_k10", 2'b10);
      at_edge(k + 25); chk("run_k25", 2'b10);
      at_edge(k + 26); chk("run_k26", 2'b11);
      at_edge(k + 33); chk("run_k33", 2'b11);
      at_edge(k + 34); chk("run_k34", 2'b00);
      at_edge(k + 60); chk("hold_k60", 2'b00);
      at_edge(k + 100); chk("hold_k100", 2'b00);
      iiA = 1'b0;

      // 3: abort four cycles into TOAST
      k = ec + 5;
      at_edge(k - 1);  iiA = 1'b1;
      at_edge(k + 3);  iiA = 1'b0;
      at_edge(k + 13); iiA = 1'b1;
      at_edge(k + 15); chk("abort_k15", 2'b10);
      at_edge(k + 16); chk("abort_k16", 2'b11);
      at_edge(k + 23); chk("abort_k23", 2'b11);
      at_edge(k + 24); chk("abort_k24", 2'b00);
      at_edge(k + 30); chk("abort_hold", 2'b00);
      iiA = 1'b0;

      // 5: presses during COOL_DOWN and on its last cycle are ignored
      k = ec + 5;
      at_edge(k - 1);  iiA = 1'b1;
      at_edge(k + 3);  iiA = 1'b0;
      at_edge(k + 27); iiA = 1'b1;
      at_edge(k + 29); iiA = 1'b0;
      at_edge(k + 30); chk("cool_press", 2'b11);
      at_edge(k + 31); iiA = 1'b1;
      at_edge(k + 34); chk("cool_end_press", 2'b00);
      at_edge(k + 40); chk("cool_after", 2'b00);
      iiA = 1'b0;
      at_edge(k + 43); iiA = 1'b1;
      at_edge(k + 45); chk("restart_k45", 2'b00);
      at_edge(k + 46); chk("restart_k46", 2'b01);

      // 6: asynchronous reset in the middle of WARMUP
      at_edge(k + 48);
      #2;
      rst = 1'b1;
      iiA = 1'b0;
      #1 chk("async_rst", 2'b00);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1 chk("post_rst_idle", 2'b00);
      k = ec + 2;
      at_edge(k - 1); iiA = 1'b1;
      at_edge(k + 2); chk("post_rst_press", 2'b01);
      iiA = 1'b0;

      // randomized button activity with occasional mid-cycle resets
      for (int i = 0; i < 160; i++) begin
         int hold;
         @(negedge clk);
         iiA  = 1'($urandom_range(0, 1));
         hold = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(1, 30);
         repeat (hold) @(negedge clk);
         if ($urandom_range(0, 24) == 0) begin
            @(posedge clk);
            #3 rst = 1'b1;
            #1 chk("rand_async_rst", 2'b00);
            @(negedge clk);
            rst = 1'b0;
         end
      end
      iiA = 1'b0;
      repeat (40) @(posedge clk);
      #1 chk("final_idle", 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
